// File: rtl/timer_pkg.sv
// Shared types for the interval timer: FSM states and count direction.
package timer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  typedef enum logic {UP, DOWN} mode_t;

endpackage

// File: rtl/tick_gen.sv
// Clock prescaler: emits one enabled tick every DIV cycles of enable.
// The phase is held while en is low, so a pause resumes mid-interval.
module tick_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] phase;

  // With DIV=1 the phase is pinned at zero, which makes tick follow en.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= '0;
    end else if (clr) begin
      phase <= '0;
    end else if (en) begin
      phase <= (phase == LAST) ? '0 : phase + PW'(1);
    end
  end

  assign tick = en && (phase == LAST);

endmodule

// File: rtl/interval_timer.sv
// Interval timer: up/down, one-shot/auto-reload counter with pause,
// runtime limit load and registered done/expire/running outputs.
module interval_timer
  import timer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DIV       = 1,
  parameter int LIMIT_DEF = 30
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] limit_in,
  input  logic             mode_down,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             done,
  output logic             expire,
  output logic             running
);

  state_t           state, state_nx;
  mode_t            mode_q, mode_nx;
  logic             reload_q, reload_nx;
  logic [WIDTH-1:0] limit_q, limit_nx;
  logic [WIDTH-1:0] count_nx;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] term_val;
  logic [WIDTH-1:0] start_in;
  logic             expire_nx;
  logic             presc_clr;
  logic             tick;

  tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (state == RUN),
    .clr   (presc_clr),
    .tick  (tick)
  );

  // Start value as selected by the live mode input, used on start and clear.
  assign start_in = mode_down ? limit_q : '0;

  // Next-state logic; clear outranks load, which outranks stop and start.
  always_comb begin
    state_nx  = state;
    mode_nx   = mode_q;
    reload_nx = reload_q;
    limit_nx  = limit_q;
    count_nx  = count;
    expire_nx = 1'b0;
    presc_clr = 1'b0;
    step_val  = (mode_q == DOWN) ? count - WIDTH'(1) : count + WIDTH'(1);
    term_val  = (mode_q == DOWN) ? '0 : limit_q;

    if (clear) begin
      state_nx  = IDLE;
      mode_nx   = mode_down ? DOWN : UP;
      count_nx  = start_in;
      presc_clr = 1'b1;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (load) begin
            limit_nx = limit_in;
          end else if (start && !stop && (limit_q != '0)) begin
            state_nx  = RUN;
            mode_nx   = mode_down ? DOWN : UP;
            reload_nx = auto_reload;
            count_nx  = start_in;
            presc_clr = 1'b1;
          end
        end
        RUN: begin
          if (tick) begin
            if (step_val == term_val) begin
              expire_nx = 1'b1;
              if (reload_q) begin
                count_nx = (mode_q == DOWN) ? limit_q : '0;
              end else begin
                count_nx = term_val;
                state_nx = DONE;
              end
            end else begin
              count_nx = step_val;
            end
          end
          // A terminal tick on the same edge as stop still finishes the run.
          if (stop && (state_nx == RUN)) begin
            state_nx = PAUSE;
          end
        end
        PAUSE: begin
          if (start && !stop) begin
            state_nx = RUN;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // State, datapath and output registers; outputs reflect the new state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      mode_q   <= UP;
      reload_q <= 1'b0;
      limit_q  <= WIDTH'(LIMIT_DEF);
      count    <= '0;
      done     <= 1'b0;
      expire   <= 1'b0;
      running  <= 1'b0;
    end else begin
      state    <= state_nx;
      mode_q   <= mode_nx;
      reload_q <= reload_nx;
      limit_q  <= limit_nx;
      count    <= count_nx;
      done     <= (state_nx == DONE);
      expire   <= expire_nx;
      running  <= (state_nx == RUN);
    end
  end

endmodule

// File: doc/interval_timer.md
# interval_timer

Parametrised interval timer for the stopwatch datapath. It generalises the fixed 30-count flag generator with these features:
- configurable width, limit and clock prescale;
- up or down counting;
- one-shot or auto-reload;
- pause/resume, runtime limit load, and separate level (`done`) and pulse (`expire`) outputs.

It sits between the stopwatch control FSM and the display/alarm logic.

## Interface
Parameters:
- `WIDTH`, 8, width of count and limit.
- `DIV`, 1, clk cycles per count step (≥1); 1 means step every cycle.
- `LIMIT_DEF`, 30, limit register value after reset.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `start` in 1: start from IDLE/DONE, resume from PAUSE.
- `stop` in 1: pause while RUN.
- `clear` in 1: synchronous return to IDLE.
- `load` in 1: write `limit_in` to the limit register; honoured in IDLE/DONE only.
- `limit_in` in WIDTH: new limit.
- `mode_down` in 1: 0 = count up 0→limit, 1 = count down limit→0. Sampled at start/clear.
- `auto_reload` in 1: 1 = periodic, 0 = one-shot. Sampled at start.
- `count` out WIDTH: current count, registered.
- `done` out 1: level; high in DONE.
- `expire` out 1: one-cycle pulse at each terminal event.
- `running` out 1: high in RUN.

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- Start value: 0 (up) or limit (down). Terminal value: limit (up) or 0 (down).
- Input priority per edge: clear > load > stop > start. `start` and `stop` together: stop wins (no state change outside RUN).
- IDLE:
  - `start` with limit ≠ 0 → RUN. On the same edge: count ← start value, mode and reload latched, prescaler cleared.
  - `start` with limit = 0 is ignored.
- RUN:
  - Each tick: count ±1.
  - On the tick where the next value equals terminal: `expire` ← 1.
    - One-shot: count ← terminal, → DONE.
    - Auto-reload: count ← start value; terminal value never visible; stay RUN. Period = limit ticks.
  - `stop` → PAUSE.
- PAUSE: count and prescaler phase held; `start` → RUN.
- DONE: count saturates at terminal, `done` = 1. `start` restarts exactly as from IDLE.
- `clear` (any state) → IDLE:
  - count ← start value per current `mode_down` input and current limit;
  - prescaler cleared, `done`/`expire` ← 0.
- `load` in RUN/PAUSE is ignored. In IDLE/DONE it updates the limit only; `count` is not changed until the next start or clear.
- Latched mode/reload inputs changing during RUN/PAUSE have no effect.
- Arithmetic is unsigned WIDTH-bit; no wrap is possible because the terminal check precedes overflow.

## Timing
- Reset values:
  - state IDLE, `count` 0, limit `LIMIT_DEF`;
  - latched mode up/one-shot;
  - `done`, `expire`, `running` all 0; prescaler 0.
- `start` sampled at edge N → `running` = 1 after edge N.
- Tick at edges N+DIV, N+2·DIV, …
- One-shot with limit L:
  - `expire` and `done` rise after edge N+L·DIV;
  - `expire` falls one edge later.
- Auto-reload: `expire` pulses every L·DIV cycles.
- Pause of P cycles delays all subsequent events by exactly P cycles; the prescaler phase is preserved.
- Outputs are registered; no combinational input→output paths.

## Structure
- Shared package `timer_pkg`: state enum (IDLE, RUN, PAUSE, DONE) and `mode_t` (UP, DOWN).
- Sub-module `tick_gen`:
  - parameter `DIV`; ports `clk`, `reset`, `en`, `clr`, `tick`;
  - counter width $clog2(DIV) (min 1);
  - `tick` = `en` && phase == DIV-1; with DIV=1, `tick` = `en`.
- Top holds the FSM, limit register, count register and output registers.

## Test plan
- Reset: pulse `reset` mid-cycle with no clock edge → `count` 0, `done` 0, `running` 0 immediately. A subsequent start counts to 30.
- Up one-shot (DIV=1, default limit): `start` at edge 0 → `count` 1..30 at edges 1..30. `expire` high only after edge 30; `done` held; `count` stays 30 for 50 further cycles.
- Down auto-reload (DIV=4), `load` 5 in IDLE, `mode_down`=1, `auto_reload`=1, start → `count` 5,4,3,2,1,5,… stepping every 4 cycles. `expire` pulses every 20 cycles; `done` stays 0.
- Pause (DIV=3, L=10, up): `stop` after 4 steps, hold 7 cycles, `start` → `count` frozen during pause. `done` rises at edge 30+7 relative to the first start.
- Collisions:
  - `start`+`stop` in RUN → PAUSE.
  - `clear`+`load` → IDLE, limit unchanged.
  - `load` during RUN → ignored.
  - limit 0 then `start` → stays IDLE, `expire` never asserted.
- Reset mid-RUN with `count` = 17 → all outputs return to reset values asynchronously. Limit reverts to 30.
